// File: rtl/reaction_pkg.sv
// Shared types and default constants for the reaction delay timer.
package reaction_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StGo,
    StDone
  } state_e;

  localparam int unsigned DefTickDiv  = 50000;
  localparam int unsigned DefMinDelay = 500;
  localparam int unsigned DefMaxReact = 9999;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running TICK_DIV divider; tick marks the last count before wrap, clear restarts from zero.
module tick_prescaler
  import reaction_pkg::*;
#(
  parameter int unsigned TICK_DIV = DefTickDiv
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LastCnt = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear || (cnt_q == LastCnt)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign tick = (cnt_q == LastCnt);

endmodule

// File: rtl/reaction_delay_timer.sv
// Random-delay GO lamp and reaction-time counter with false-start and timeout detection.
// Define REACTION_BEST_TIME_EN to keep a running best (minimum) valid reaction in best_ms.
module reaction_delay_timer
  import reaction_pkg::*;
#(
  parameter int unsigned N         = 12,
  parameter int unsigned TICK_DIV  = DefTickDiv,
  parameter int unsigned MIN_DELAY = DefMinDelay,
  parameter int unsigned RW        = 14,
  parameter int unsigned MAX_REACT = DefMaxReact
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic [N-1:0]  random,
  output logic          downcount,
  output logic          led_go,
  output logic [RW-1:0] reaction_ms,
  output logic          result_valid,
  output logic          false_start,
  output logic          timeout,
  output logic [RW-1:0] best_ms
);

  localparam logic [N:0]    MinDelayW = (N + 1)'(MIN_DELAY);
  localparam logic [N:0]    DelayOne  = (N + 1)'(1);
  localparam logic [RW-1:0] LastReact = RW'(MAX_REACT - 1);

  state_e        state_q, state_d;
  logic [N:0]    delay_q, delay_d;
  logic [RW-1:0] react_q, react_d;
  logic          rv_q, rv_d;
  logic          fs_q, fs_d;
  logic          to_q, to_d;
  logic          dc_q, go_q;
  logic          tick, presc_clear;

  // Prescaler restarts on every state change and stays at zero outside WAIT/GO.
  assign presc_clear = (state_d != state_q) || (state_q == StIdle) || (state_q == StDone);

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .clear(presc_clear),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    delay_d = delay_q;
    react_d = react_q;
    rv_d    = rv_q;
    fs_d    = fs_q;
    to_d    = to_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StWait;
          delay_d = {1'b0, random} + MinDelayW;
          react_d = '0;
          rv_d    = 1'b0;
          fs_d    = 1'b0;
          to_d    = 1'b0;
        end
      end
      StWait: begin
        // A stop coinciding with the final tick still counts as a false start.
        if (stop) begin
          state_d = StDone;
          fs_d    = 1'b1;
          react_d = '0;
        end else if (tick) begin
          delay_d = delay_q - DelayOne;
          if (delay_q == DelayOne) begin
            state_d = StGo;
          end
        end
      end
      StGo: begin
        if (stop) begin
          state_d = StDone;
          rv_d    = 1'b1;
        end else if (tick) begin
          react_d = react_q + RW'(1);
          if (react_q == LastReact) begin
            state_d = StDone;
            to_d    = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      delay_q <= '0;
      react_q <= '0;
      rv_q    <= 1'b0;
      fs_q    <= 1'b0;
      to_q    <= 1'b0;
      dc_q    <= 1'b0;
      go_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      delay_q <= delay_d;
      react_q <= react_d;
      rv_q    <= rv_d;
      fs_q    <= fs_d;
      to_q    <= to_d;
      dc_q    <= (state_d == StWait);
      go_q    <= (state_d == StGo);
    end
  end

`ifdef REACTION_BEST_TIME_EN
  logic [RW-1:0] best_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      best_q <= '1;
    end else if ((state_q == StGo) && stop && (react_q < best_q)) begin
      best_q <= react_q;
    end
  end

  assign best_ms = best_q;
`else
  assign best_ms = '1;
`endif

  assign downcount    = dc_q;
  assign led_go       = go_q;
  assign reaction_ms  = react_q;
  assign result_valid = rv_q;
  assign false_start  = fs_q;
  assign timeout      = to_q;

endmodule

// File: tb/tb_reaction_delay_timer.sv
// Bench for reaction_delay_timer: directed vector table, corner sequences, then random traffic
// checked against a timestamp-based model of the attempt.
module tb_reaction_delay_timer;

  localparam int unsigned N    = 4;
  localparam int unsigned TD   = 4;
  localparam int unsigned MIND = 2;
  localparam int unsigned RW   = 4;
  localparam int unsigned MAXR = 10;

  logic          clk = 1'b0;
  logic          reset, start, stop;
  logic [N-1:0]  random;
  logic          downcount, led_go, result_valid, false_start, timeout;
  logic [RW-1:0] reaction_ms, best_ms;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  reaction_delay_timer #(
    .N(N), .TICK_DIV(TD), .MIN_DELAY(MIND), .RW(RW), .MAX_REACT(MAXR)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .random(random),
    .downcount(downcount), .led_go(led_go), .reaction_ms(reaction_ms),
    .result_valid(result_valid), .false_start(false_start), .timeout(timeout),
    .best_ms(best_ms)
  );

  typedef struct {
    logic [N-1:0] rnd;
    int           stop_at;   // edge (after start edge) where stop is sampled; 0 = never
    int           exp_go;    // edge where led_go is first seen high; 0 = never
    logic         exp_rv, exp_fs, exp_to;
    int           exp_react;
    int           exp_best;  // best_ms after this attempt when best tracking is built in
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int pack_outs();
    return int'({downcount, led_go, result_valid, false_start, timeout, reaction_ms, best_ms});
  endfunction

  function automatic int pack_exp(bit dc, bit lg, bit rv, bit fs, bit to, int re, int be);
    logic [RW-1:0] r4, b4;
    r4 = RW'(re);
    b4 = RW'(be);
    return int'({dc, lg, rv, fs, to, r4, b4});
  endfunction

  function automatic int best_exp(int b);
`ifdef REACTION_BEST_TIME_EN
    return b;
`else
    return b - b + 15;
`endif
  endfunction

  task automatic run_attempt(input vec_t v, input int idx);
    int go_seen = 0;
    bit done = 0;
    random = v.rnd;
    start = 1'b1;
    step();
    start = 1'b0;
    check($sformatf("v%0d arm", idx), {30'd0, downcount, led_go}, 2);
    for (int k = 1; k <= 200 && !done; k++) begin
      stop = (k == v.stop_at);
      step();
      stop = 1'b0;
      if (led_go && go_seen == 0) go_seen = k;
      if (result_valid || false_start || timeout) done = 1;
    end
    check($sformatf("v%0d done_in_budget", idx), int'(done), 1);
    check($sformatf("v%0d go_edge", idx), go_seen, v.exp_go);
    check($sformatf("v%0d flags", idx),
          int'({downcount, led_go, result_valid, false_start, timeout}),
          int'({1'b0, 1'b0, v.exp_rv, v.exp_fs, v.exp_to}));
    check($sformatf("v%0d reaction", idx), int'(reaction_ms), v.exp_react);
    check($sformatf("v%0d best", idx), int'(best_ms), best_exp(v.exp_best));
  endtask

  // Reference model: an armed attempt is described by the edge at which GO begins.
  int  m_mode;  // 0 idle, 1 armed, 2 done
  int  m_go, m_react, m_best;
  bit  m_rv, m_fs, m_to;

  task automatic model_edge(input int e, input bit s, input bit p, input int r);
    if (m_mode != 1) begin
      if (s) begin
        m_mode = 1; m_go = e + (MIND + r) * TD;
        m_rv = 0; m_fs = 0; m_to = 0; m_react = 0;
      end
    end else if (p) begin
      m_mode = 2;
      if (e <= m_go) begin
        m_fs = 1; m_react = 0;
      end else begin
        m_rv = 1; m_react = (e - m_go - 1) / TD;
        if (m_react < m_best) m_best = m_react;
      end
    end else if (e == m_go + MAXR * TD) begin
      m_mode = 2; m_to = 1; m_react = MAXR;
    end
  endtask

  function automatic int model_outs(int e);
    bit dc, lg;
    int re;
    dc = (m_mode == 1) && (e < m_go);
    lg = (m_mode == 1) && (e >= m_go);
    re = (m_mode == 1) ? (lg ? (e - m_go) / TD : 0) : m_react;
    return pack_exp(dc, lg, m_rv, m_fs, m_to, re, best_exp(m_best));
  endfunction

  initial begin
    bit seen;
    //          rnd   stop  go  rv    fs    to    react best
    vecs[0] = '{4'd3,  49,  20, 1'b1, 1'b0, 1'b0, 7,    7};
    vecs[1] = '{4'd1,  30,  12, 1'b1, 1'b0, 1'b0, 4,    4};
    vecs[2] = '{4'd3,  10,  0,  1'b0, 1'b1, 1'b0, 0,    4};
    vecs[3] = '{4'd5,  68,  28, 1'b1, 1'b0, 1'b0, 9,    4};
    vecs[4] = '{4'd3,  20,  0,  1'b0, 1'b1, 1'b0, 0,    4};
    vecs[5] = '{4'd15, 0,   68, 1'b0, 1'b0, 1'b1, 10,   4};
    vecs[6] = '{4'd0,  12,  8,  1'b1, 1'b0, 1'b0, 0,    0};

    reset = 1'b1; start = 1'b0; stop = 1'b0; random = '0;
    #12;
    check("reset_state", pack_outs(), pack_exp(0, 0, 0, 0, 0, 0, 15));
    step();
    reset = 1'b0;
    step();
    check("idle_after_reset", pack_outs(), pack_exp(0, 0, 0, 0, 0, 0, 15));

    foreach (vecs[i]) run_attempt(vecs[i], i);

    // start and stop together in IDLE: start wins
    reset = 1'b1; step(); reset = 1'b0; step();
    random = 4'd2; start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    check("start_stop_idle", int'({downcount, false_start, result_valid}), 4);

    // asynchronous reset in the middle of GO
    seen = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      step();
      seen = led_go;
    end
    check("reach_go", int'(seen), 1);
    step(); step();
    #2 reset = 1'b1;
    #1 check("async_reset_go", pack_outs(), pack_exp(0, 0, 0, 0, 0, 0, 15));
    step();
    reset = 1'b0;

    // random traffic against the model
    m_mode = 0; m_go = 0; m_react = 0; m_best = 15; m_rv = 0; m_fs = 0; m_to = 0;
    for (int e = 1; e <= 4000; e++) begin
      bit s, p;
      int r;
      s = ($urandom_range(0, 19) == 0);
      p = ($urandom_range(0, 29) == 0);
      r = int'($urandom_range(0, 15));
      start = s; stop = p; random = N'(r);
      step();
      model_edge(e, s, p, r);
      check($sformatf("rand_e%0d", e), pack_outs(), model_outs(e));
    end
    start = 1'b0; stop = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
